// File: rtl/debounce_pkg.sv
// debounce_pkg: shared helpers for the multi-channel debouncer.
// Holds the ceil-log2 helper and the parameter legality checks used by
// debounce_multi and debounce_channel.
package debounce_pkg;

  // Bits needed to count 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit depth_legal(input int depth);
    return depth >= 2;
  endfunction

  function automatic bit prescale_legal(input int prescale);
    return prescale >= 1;
  endfunction

  function automatic bit hold_legal(input int hold_ticks);
    return hold_ticks >= 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel.
// A DEPTH-sample agreement window sets/clears the debounced level, emits
// one-clk rise/fall pulses on level changes, and a one-shot held pulse once
// the level has been high for HOLD_TICKS sample ticks.
// The window is the DEPTH-1 stored samples plus the incoming sample, so the
// decision sees the post-shift contents on the same tick edge.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 250
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_s,
  output logic o_debounced,
  output logic o_rise,
  output logic o_fall,
  output logic o_held
);

  localparam int HOLD_W = clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  if (!depth_legal(DEPTH) || !hold_legal(HOLD_TICKS)) begin : g_bad_params
    $error("debounce_channel: DEPTH must be >= 2 and HOLD_TICKS >= 1");
  end

  logic [DEPTH-2:0]  r_shreg;
  logic [DEPTH-1:0]  w_window;
  logic              r_debounced;
  logic              r_rise;
  logic              r_fall;
  logic              r_held;
  logic [HOLD_W-1:0] r_hold_cnt;

  assign w_window = {r_shreg, i_s};

  // Shift in a sample on each tick and update the level on full agreement.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shreg     <= '0;
      r_debounced <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_tick) begin
        r_shreg <= w_window[DEPTH-2:0];
        if ((&w_window) && !r_debounced) begin
          r_debounced <= 1'b1;
          r_rise      <= 1'b1;
        end else if (!(|w_window) && r_debounced) begin
          r_debounced <= 1'b0;
          r_fall      <= 1'b1;
        end
      end
    end
  end

  // Count ticks while high, saturate at HOLD_TICKS, pulse once on arrival.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold_cnt <= '0;
      r_held     <= 1'b0;
    end else begin
      r_held <= 1'b0;
      if (!r_debounced) begin
        r_hold_cnt <= '0;
      end else if (i_tick && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
        if (r_hold_cnt == (HOLD_MAX - 1'b1)) begin
          r_held <= 1'b1;
        end
      end
    end
  end

  assign o_debounced = r_debounced;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_held      = r_held;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: parametrised multi-channel push-button debouncer.
// Owns the sample-rate prescaler and the optional input synchroniser, and
// instantiates one debounce_channel per button.
// Build option DEBOUNCE_SYNC_EN: when defined, each button passes through a
// 2-flop synchroniser (2 clk extra latency); otherwise buttons must already
// be synchronous to i_clk.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 8,
  parameter int PRESCALE   = 1,
  parameter int HOLD_TICKS = 250
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_button,
  output logic [CHANNELS-1:0] o_debounced,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_held,
  output logic                o_tick
);

  localparam int CNT_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  if (!prescale_legal(PRESCALE) || (CHANNELS < 1)) begin : g_bad_params
    $error("debounce_multi: PRESCALE and CHANNELS must be >= 1");
  end

  logic [CNT_W-1:0]    r_cnt;
  logic                r_tick;
  logic [CHANNELS-1:0] w_s;

  // Prescaler: wrap at PRESCALE-1 and register a one-clk tick on the wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CNT_MAX);
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  // Two-flop synchroniser, clocked every clk regardless of tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_button;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .DEPTH      (DEPTH),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_chan (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tick      (r_tick),
      .i_s         (w_s[g]),
      .o_debounced (o_debounced[g]),
      .o_rise      (o_rise[g]),
      .o_fall      (o_fall[g]),
      .o_held      (o_held[g])
    );
  end

  assign o_tick = r_tick;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed bench for debounce_multi.
// Main instance: CHANNELS=4, DEPTH=4, PRESCALE=3, HOLD_TICKS=5.
// Second instance with PRESCALE=1 exposes the exact clk latency of the
// sample path (4 clk, or 6 clk with DEBOUNCE_SYNC_EN).
module tb_debounce_multi;

  logic       clk;
  logic       reset;
  logic [3:0] button;
  logic [3:0] deb, rise, fall, held;
  logic       tick;

  logic b2, deb2, rise2, fall2, held2, tick2;

  int total = 0;
  int bad   = 0;
  int n_rise [4];
  int n_fall [4];
  int n_held [4];
  int n_both = 0;

  debounce_multi #(
    .CHANNELS (4), .DEPTH (4), .PRESCALE (3), .HOLD_TICKS (5)
  ) dut (
    .i_clk (clk), .i_reset (reset), .i_button (button),
    .o_debounced (deb), .o_rise (rise), .o_fall (fall), .o_held (held),
    .o_tick (tick)
  );

  debounce_multi #(
    .CHANNELS (1), .DEPTH (4), .PRESCALE (1), .HOLD_TICKS (5)
  ) dut2 (
    .i_clk (clk), .i_reset (reset), .i_button (b2),
    .o_debounced (deb2), .o_rise (rise2), .o_fall (fall2), .o_held (held2),
    .o_tick (tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk, sampled 1 time unit after the edge; tallies pulses per channel.
  task automatic clk_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      n_rise[c] += int'(rise[c]);
      n_fall[c] += int'(fall[c]);
      n_held[c] += int'(held[c]);
      if (rise[c] && fall[c]) n_both++;
    end
  endtask

  // Advance to just after the next edge at which tick was high.
  task automatic tick_edge();
    logic t;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      t = tick;
      clk_step();
      if (t) found = 1'b1;
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL tick_timeout: observed=no tick expected=tick within 8 clk");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tick, first_tick, last_tick, gap_bad, lat;
    int f0_snap, f3_snap, r_snap;
    for (int c = 0; c < 4; c++) begin
      n_rise[c] = 0; n_fall[c] = 0; n_held[c] = 0;
    end
    reset  = 1'b1;
    button = 4'b0000;
    b2     = 1'b0;
    #22;
    chk("reset_outputs", {15'b0, deb, rise, fall, held, tick}, 32'h0);
    chk("reset_outputs2", {27'b0, deb2, rise2, fall2, held2, tick2}, 32'h0);
    reset = 1'b0;

    // Idle: tick every 3rd clk, no activity.
    n_tick = 0; first_tick = 0; last_tick = 0; gap_bad = 0;
    for (int j = 1; j <= 50; j++) begin
      clk_step();
      if (tick) begin
        n_tick++;
        if (last_tick != 0 && (j - last_tick) != 3) gap_bad++;
        if (first_tick == 0) first_tick = j;
        last_tick = j;
      end
    end
    chk("idle_first_tick", first_tick, 3);
    chk("idle_tick_count", n_tick, 16);
    chk("idle_tick_gap", gap_bad, 0);
    chk("idle_debounced", {28'b0, deb}, 0);
    chk("idle_pulses", n_rise[0]+n_rise[1]+n_rise[2]+n_rise[3]+n_fall[0]+n_fall[1]
        +n_fall[2]+n_fall[3]+n_held[0]+n_held[1]+n_held[2]+n_held[3], 0);

    // Clean press on channel 0, then release.
    tick_edge();
    button = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      tick_edge();
      chk($sformatf("press0_deb_t%0d", k), {28'b0, deb}, (k == 4) ? 4'b0001 : 4'b0000);
      chk($sformatf("press0_rise_t%0d", k), {28'b0, rise}, (k == 4) ? 4'b0001 : 4'b0000);
    end
    chk("press0_fall", {28'b0, fall}, 0);
    button = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      tick_edge();
      chk($sformatf("release0_fall_t%0d", k), {28'b0, fall}, (k == 4) ? 4'b0001 : 4'b0000);
    end
    chk("press0_rise_width", n_rise[0], 1);
    chk("press0_fall_width", n_fall[0], 1);
    chk("press0_no_held", n_held[0]+n_held[1]+n_held[2]+n_held[3], 0);

    // Bounce on channel 1: 1,0,1,0 then stable 1.
    for (int k = 0; k < 4; k++) begin
      button[1] = (k % 2 == 0);
      tick_edge();
      chk($sformatf("bounce_deb_t%0d", k), {28'b0, deb}, 0);
    end
    chk("bounce_no_rise", n_rise[1], 0);
    button[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick_edge();
      chk($sformatf("stable1_deb_t%0d", k), {28'b0, deb}, (k == 4) ? 4'b0010 : 4'b0000);
    end
    chk("stable1_rise", n_rise[1], 1);
    button[1] = 1'b0;
    repeat (4) tick_edge();
    chk("release1_deb", {28'b0, deb}, 0);

    // Long press on channel 2: rise at tick 4, held at tick 9 only.
    button[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_edge();
      chk($sformatf("long_rise_t%0d", k), {31'b0, rise[2]}, (k == 4) ? 1 : 0);
      chk($sformatf("long_held_t%0d", k), {31'b0, held[2]}, (k == 9) ? 1 : 0);
      chk($sformatf("long_deb_t%0d", k), {31'b0, deb[2]}, (k >= 4) ? 1 : 0);
    end
    chk("long_held_once", n_held[2], 1);
    button[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick_edge();
      chk($sformatf("long_fall_t%0d", k), {31'b0, fall[2]}, (k == 4) ? 1 : 0);
    end
    // Second press: held again at tick 9 proves the counter was cleared.
    button[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick_edge();
      if (k >= 8) chk($sformatf("repress_held_t%0d", k), {31'b0, held[2]}, (k == 9) ? 1 : 0);
    end
    button[2] = 1'b0;
    repeat (4) tick_edge();
    chk("repress_held_total", n_held[2], 2);
    chk("repress_deb", {28'b0, deb}, 0);

    // Simultaneous press on channels 0 and 3.
    button = 4'b1001;
    repeat (3) tick_edge();
    chk("simul_before", {28'b0, rise}, 0);
    tick_edge();
    chk("simul_rise", {28'b0, rise}, 4'b1001);
    chk("simul_deb", {28'b0, deb}, 4'b1001);

    // Release, then reset two ticks into the release window.
    button = 4'b0000;
    repeat (2) tick_edge();
    chk("prereset_deb", {28'b0, deb}, 4'b1001);
    f0_snap = n_fall[0];
    f3_snap = n_fall[3];
    r_snap  = n_rise[0] + n_rise[3];
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {15'b0, deb, rise, fall, held, tick}, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("inreset_outputs", {15'b0, deb, rise, fall, held, tick}, 0);
    reset = 1'b0;
    repeat (6) tick_edge();
    chk("postreset_fall0", n_fall[0], f0_snap);
    chk("postreset_fall3", n_fall[3], f3_snap);
    chk("postreset_rise", n_rise[0] + n_rise[3], r_snap);
    chk("postreset_deb", {28'b0, deb}, 0);
    chk("never_rise_and_fall", n_both, 0);

    // Exact clk latency on the PRESCALE=1 instance.
    b2  = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      lat++;
      if (rise2) break;
    end
`ifdef DEBOUNCE_SYNC_EN
    chk("p1_rise_latency", lat, 6);
`else
    chk("p1_rise_latency", lat, 4);
`endif
    chk("p1_deb", {31'b0, deb2}, 1);
    clk_step();
    chk("p1_rise_width", {31'b0, rise2}, 0);
    chk("p1_deb_hold", {31'b0, deb2}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel push-button debouncer.
- Samples CHANNELS raw button inputs at a prescaled rate and filters each through a DEPTH-sample agreement window.
- Emits per-channel debounced levels, one-cycle rise/fall pulses, and a one-shot long-press pulse.
- Sits between board pins and the user-control logic (mixer/encoder front end).

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEPTH, 8, consecutive identical samples required to change state (>=2).
- PRESCALE, 1, clk cycles per sample tick (>=1); 1 = sample every cycle.
- HOLD_TICKS, 250, sample ticks of continuous debounced-high before the long-press pulse (>=1).

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- button  in  CHANNELS  raw, possibly bouncing inputs; bit i is channel i.
- debounced  out  CHANNELS  filtered level per channel.
- rise  out  CHANNELS  one-clk pulse when debounced[i] goes 0->1.
- fall  out  CHANNELS  one-clk pulse when debounced[i] goes 1->0.
- held  out  CHANNELS  one-clk pulse when channel i has stayed debounced-high for HOLD_TICKS ticks.
- tick  out  1  sample strobe, one clk high per sample period (bench/observability use).

Behaviour:
- Reset (async, active-high): prescaler counter=0, all shift registers=0, debounced=0, rise=fall=held=0, hold counters=0, tick=0. Asserting reset mid-operation aborts any pending change; no pulses are emitted on reset entry or exit.
- Prescaler: counter width max(1,clog2(PRESCALE)); increments each clk and wraps from PRESCALE-1 to 0. tick is registered high in the cycle the counter wraps. PRESCALE=1: tick is high every cycle after reset is released.
- Sample path: on a clk edge with tick=1, shreg[i] <= {shreg[i][DEPTH-2:0], s[i]}, where s is the sample input (see Optional Feature). With tick=0, shreg holds.
- Decision: evaluated on the post-shift value of shreg. On the tick edge where the new value is all-ones, debounced[i]<=1; all-zeros, debounced[i]<=0; otherwise debounced[i] holds. Latency: debounced changes on the DEPTH-th consecutive identical sample tick.
- Edges: rise[i]/fall[i] are registered on the same edge that debounced[i] changes and are high for exactly one clk, even when PRESCALE>1. Rise and fall are never both high on the same channel.
- Hold counter: per channel, width clog2(HOLD_TICKS+1).
  - Cleared whenever debounced[i]=0.
  - While debounced[i]=1, increments on each tick and saturates at HOLD_TICKS.
  - held[i] pulses for one clk on the tick edge where the counter reaches HOLD_TICKS; exactly once per press, with no repeat while still held.
- Channels are fully independent. Simultaneous events on several channels all produce their pulses on the same cycle.
- Bounce shorter than DEPTH ticks produces no output change and no pulses.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: each button bit passes through a 2-flop synchroniser, clocked every clk (not gated by tick) and reset to 0; s = sync output. Adds 2 clk of latency before sampling.
- Undefined: s = button directly; the input must be synchronous to clk upstream.
- All other behaviour is identical in both builds.

Decomposition:
- Package debounce_pkg holds the clog2 helper function and the parameter legality checks (DEPTH>=2, PRESCALE>=1, HOLD_TICKS>=1), shared by both modules.
- Sub-module debounce_channel: one channel, containing shreg, decision, edge pulses and hold counter. Inputs: clk, reset, tick, s. Outputs: debounced, rise, fall, held.
- Top-level debounce_multi: owns the prescaler and the optional synchroniser; generate-instantiates CHANNELS copies of debounce_channel.

Test Plan:
Bench configuration: CHANNELS=4, DEPTH=4, PRESCALE=3, HOLD_TICKS=5, macro undefined unless stated.
- Reset then idle: every output is 0 and tick pulses every 3rd clk -> debounced=4'b0000, no rise/fall/held for 50 clk.
- Clean press: button[0]=1 held -> debounced[0]=1 and rise[0] pulse (1 clk wide) on the 4th tick; fall/held stay 0 on all channels.
- Bounce rejection: button[1] toggles 1,0,1,0 on successive ticks, then goes stable 1 -> no change during the toggling; debounced[1] rises on the 4th stable tick.
- Long press: button[2] stays high 12 ticks -> rise[2] at tick 4 and held[2] one pulse at tick 9; no further held. Release -> fall[2] 4 ticks after release; held counter back to 0.
- Simultaneous/mid-op reset: buttons 4'b1001 pressed together -> rise=4'b1001 in the same clk. Then assert reset after 2 ticks of a release -> all outputs 0 immediately and no fall pulse after reset is released.
- DEBOUNCE_SYNC_EN defined: repeat the clean press -> same result, delayed by exactly 2 clk relative to the undefined build.
